// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 mux path between 8 requesters.
// Grants one source, registers its data word, and holds it on a valid/ready port
// until accepted. IDLE between grants is a mandatory bubble so that a source can
// drop req on its done pulse before the next pick.
module mux8_rr_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         req,
    input  logic [8*WIDTH-1:0] in_data,
    output logic [7:0]         gnt,
    output logic [7:0]         done,
    output logic [2:0]         sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e           state_q, state_d;
    logic [7:0]       gnt_q, gnt_d;
    logic [2:0]       sel_q, sel_d;
    logic [2:0]       ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic             pick_found;
    logic [2:0]       pick_idx;
    logic [2:0]       cand;

    // Rotating priority scan: ptr has highest priority, ptr-1 (last granted) lowest.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 3'd0;
        cand       = 3'd0;
        for (int k = 0; k < 8; k++) begin
            cand = ptr_q + 3'(k);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state: capture on grant in IDLE, hold everything in BUSY until accepted.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    gnt_d   = 8'd1 << pick_idx;
                    sel_d   = pick_idx;
                    data_d  = in_data[pick_idx*WIDTH +: WIDTH];
                    valid_d = 1'b1;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (out_ready) begin
                    gnt_d   = 8'd0;
                    valid_d = 1'b0;
                    ptr_d   = sel_q + 3'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; async clear drops any in-flight word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= 8'd0;
            sel_q   <= 3'd0;
            ptr_q   <= 3'd0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // done is combinational so the source sees it in the accepting cycle.
    always_comb begin
        done = 8'd0;
        if (state_q == StBusy && out_ready) begin
            done = gnt_q;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter with hand-computed expectations.
module tb_mux8_rr_arbiter;

    localparam int unsigned W = 8;

    logic           clk;
    logic           rst_n;
    logic [7:0]     req;
    logic [8*W-1:0] in_data;
    logic [7:0]     gnt;
    logic [7:0]     done;
    logic [2:0]     sel;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;

    int n_checks;
    int n_pass;

    mux8_rr_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in_data   (in_data),
        .gnt       (gnt),
        .done      (done),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [W-1:0] val);
        in_data[idx*W +: W] = val;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        req       = 8'h00;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_done", 32'(done), 32'h0);

        // Single request from source 5
        rst_n     = 1'b1;
        set_data(5, 8'hA5);
        req       = 8'h20;
        out_ready = 1'b1;
        tick();
        check("single_gnt", 32'(gnt), 32'h20);
        check("single_sel", 32'(sel), 32'd5);
        check("single_data", 32'(out_data), 32'hA5);
        check("single_valid", 32'(out_valid), 32'h1);
        check("single_done", 32'(done), 32'h20);
        req = 8'h00;
        tick();
        check("single_idle_valid", 32'(out_valid), 32'h0);
        check("single_idle_gnt", 32'(gnt), 32'h0);

        // Priority skip: ptr=6, req=05 -> 0 then 2
        req = 8'h05;
        tick();
        check("skip_gnt0", 32'(gnt), 32'h01);
        check("skip_sel0", 32'(sel), 32'd0);
        check("skip_done0", 32'(done), 32'h01);
        req = 8'h04;
        tick();
        tick();
        check("skip_gnt2", 32'(gnt), 32'h04);
        check("skip_sel2", 32'(sel), 32'd2);
        req = 8'h00;
        tick();

        // Backpressure on source 3 (ptr=3)
        set_data(3, 8'h33);
        req       = 8'h08;
        out_ready = 1'b0;
        tick();
        check("bp_gnt", 32'(gnt), 32'h08);
        check("bp_done0", 32'(done), 32'h0);
        for (int i = 0; i < 5; i++) begin
            set_data(3, 8'(8'h80 + i));
            tick();
            check("bp_hold_data", 32'(out_data), 32'h33);
            check("bp_hold_sel", 32'(sel), 32'd3);
            check("bp_hold_gnt", 32'(gnt), 32'h08);
            check("bp_hold_done", 32'(done), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_done", 32'(done), 32'h08);
        req = 8'h00;
        tick();
        check("bp_done_after", 32'(done), 32'h0);
        check("bp_valid_after", 32'(out_valid), 32'h0);

        // Withdraw during BUSY (ptr=4)
        set_data(4, 8'h44);
        req       = 8'h10;
        out_ready = 1'b0;
        tick();
        check("wd_gnt", 32'(gnt), 32'h10);
        req = 8'h00;
        tick();
        check("wd_data", 32'(out_data), 32'h44);
        check("wd_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        #1;
        check("wd_done", 32'(done), 32'h10);
        tick();
        tick();
        check("wd_no_regrant", 32'(gnt), 32'h0);
        check("wd_idle_valid", 32'(out_valid), 32'h0);
        check("idle_ready_done", 32'(done), 32'h0);

        // Reset mid-BUSY (ptr=5, req=FF -> grant 5)
        req       = 8'hFF;
        out_ready = 1'b0;
        tick();
        check("pre_rst_gnt", 32'(gnt), 32'h20);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'h0);
        check("async_rst_valid", 32'(out_valid), 32'h0);
        check("async_rst_sel", 32'(sel), 32'h0);
        check("async_rst_done", 32'(done), 32'h0);
        tick();
        rst_n = 1'b1;

        // Round robin with all requesting, including wrap 7 -> 0
        for (int i = 0; i < 8; i++) set_data(i, 8'(8'h10 + 8'h11 * i));
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("rr_sel", 32'(sel), 32'(i % 8));
            check("rr_gnt", 32'(gnt), 32'(8'd1 << (i % 8)));
            check("rr_data", 32'(out_data), 32'(8'(8'h10 + 8'h11 * (i % 8))));
            check("rr_done", 32'(done), 32'(8'd1 << (i % 8)));
            tick();
            check("rr_bubble", 32'(out_valid), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
